serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single `full_adder` instance over W cycles to add two W-bit operands plus carry-in, LSB first. Accepts one operand set through a valid/ready slave handshake, runs the carry-chain serially with a carry flop, and presents the W-bit sum and carry-out through a valid/ready master handshake. It trades latency for area and sits as the narrow-datapath arithmetic engine for small control units.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Bit counter width; a single-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the bit-slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder walks the carry chain LSB first over W
// cycles; operands enter on a valid/ready slave port, the result leaves on
// a valid/ready master port.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         busy
);

  localparam int CW = cnt_width(W);

  sa_state_t       state_q;
  sa_state_t       state_nxt;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nxt;
  logic [W-1:0]    sum_q;
  logic            carry;
  logic            co_q;
  logic [CW-1:0]   cnt;
  logic            last_bit;
  logic            fa_sum;
  logic            fa_co;

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // Shift the accumulator right and drop the new sum bit into the MSB.
  always_comb begin
    acc_nxt        = acc >> 1;
    acc_nxt[W-1]   = fa_sum;
    last_bit       = (cnt == CW'(W - 1));
  end

  // State register plus operand shifters, carry flop, counter and result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ci;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_nxt;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum_q <= acc_nxt;
            co_q  <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode: accept in IDLE, leave RUN after the last bit, hold DONE until taken.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (s_valid)  state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (m_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from registered state only.
  always_comb begin
    s_ready = (state_q == IDLE);
    m_valid = (state_q == DONE);
    busy    = (state_q != IDLE);
  end

  assign sum = sum_q;
  assign co  = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a W=8 and a W=1 instance.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // W = 8 instance
  logic       s_valid8 = 1'b0, s_ready8, m_valid8, m_ready8 = 1'b1, co8, ci8 = 1'b0, busy8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  // W = 1 instance
  logic       s_valid1 = 1'b0, s_ready1, m_valid1, m_ready1 = 1'b1, co1, ci1 = 1'b0, busy1;
  logic [0:0] a1 = '0, b1 = '0, sum1;

  serial_adder_ctrl #(.W(8)) dut8 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid8), .s_ready(s_ready8),
    .a(a8), .b(b8), .ci(ci8), .m_valid(m_valid8), .m_ready(m_ready8),
    .sum(sum8), .co(co8), .busy(busy8)
  );

  serial_adder_ctrl #(.W(1)) dut1 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid1), .s_ready(s_ready1),
    .a(a1), .b(b1), .ci(ci1), .m_valid(m_valid1), .m_ready(m_ready1),
    .sum(sum1), .co(co1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] sum;
    logic       co;
    int         acc_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  exp_t q8[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_mv8 = 1'b0;
  logic prev_mv1 = 1'b0;

  // Hand-computed vectors for the back-to-back stream.
  vec_t tbl [12] = '{
    '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0},
    '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0},
    '{8'hAB, 8'hCD, 1'b0, 8'h78, 1'b1},
    '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1},
    '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0},
    '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1},
    '{8'h99, 8'h66, 1'b0, 8'hFF, 1'b0},
    '{8'hE1, 8'h2F, 1'b1, 8'h11, 1'b1},
    '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present one operand set and push its expected result once accepted.
  task automatic send(input bit w1, input logic [7:0] av, input logic [7:0] bv,
                      input logic civ, input logic [7:0] es, input logic ec);
    bit   done = 1'b0;
    exp_t e;
    if (w1) begin
      s_valid1 = 1'b1; a1 = av[0:0]; b1 = bv[0:0]; ci1 = civ;
    end else begin
      s_valid8 = 1'b1; a8 = av; b8 = bv; ci8 = civ;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rstn && (w1 ? s_ready1 : s_ready8)) begin
        e.sum = es; e.co = ec; e.acc_cyc = cyc;
        if (w1) q1.push_back(e); else q8.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (w1) s_valid1 = 1'b0; else s_valid8 = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (q8.size() == 0 && q1.size() == 0 && !m_valid8 && !m_valid1) break;
      @(posedge clk); #1;
    end
    check("drain_q8", q8.size(), 0);
    check("drain_q1", q1.size(), 0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    q8.delete();
    q1.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    check("rst_s_ready", s_ready8, 1);
    check("rst_m_valid", m_valid8, 0);
    check("rst_busy",    busy8,    0);
    check("rst_sum",     sum8,     0);
    check("rst_co",      co8,      0);
  endtask

  // Monitor for the W=8 instance: latency on m_valid rise, data on handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_mv8 = 1'b0;
    end else begin
      if (m_valid8 && !prev_mv8) begin
        if (q8.size() == 0) check("w8_unexpected", m_valid8, 0);
        else check("w8_latency", cyc - q8[0].acc_cyc, 9);
      end
      if (m_valid8 && m_ready8 && q8.size() != 0) begin
        exp_t e;
        e = q8.pop_front();
        check("w8_sum", sum8, e.sum);
        check("w8_co",  co8,  e.co);
      end
      prev_mv8 = m_valid8;
    end
  end

  // Monitor for the W=1 instance.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_mv1 = 1'b0;
    end else begin
      if (m_valid1 && !prev_mv1) begin
        if (q1.size() == 0) check("w1_unexpected", m_valid1, 0);
        else check("w1_latency", cyc - q1[0].acc_cyc, 2);
      end
      if (m_valid1 && m_ready1 && q1.size() != 0) begin
        exp_t e;
        e = q1.pop_front();
        check("w1_sum", sum1, e.sum);
        check("w1_co",  co1,  e.co);
      end
      prev_mv1 = m_valid1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #1;
    apply_reset();
    check("rst_w1_s_ready", s_ready1, 1);
    check("rst_w1_sum",     sum1,     0);

    // Basic add, result taken immediately, back to IDLE.
    send(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    drain();
    check("idle_s_ready", s_ready8, 1);
    check("idle_busy",    busy8,    0);

    // Carry-out boundaries.
    send(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    send(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    drain();

    // Backpressure: stall five cycles in DONE, poke s_valid meanwhile.
    m_ready8 = 1'b0;
    send(1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (m_valid8) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("bp_reached_done", got, 1);
    for (int i = 0; i < 5; i++) begin
      s_valid8 = (i == 2);
      a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
      @(negedge clk);
      check("bp_m_valid", m_valid8, 1);
      check("bp_sum",     sum8,     8'h47);
      check("bp_co",      co8,      0);
      check("bp_s_ready", s_ready8, 0);
      @(posedge clk); #1;
    end
    s_valid8 = 1'b0;
    m_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_s_ready", s_ready8, 1);
    check("bp_release_m_valid", m_valid8, 0);
    drain();

    // Reset in the middle of RUN discards the operation.
    send(1'b0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_run_busy", busy8, 1);
    apply_reset();
    send(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    drain();

    // Single-bit build.
    send(1'b1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1);
    send(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    send(1'b1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0);
    send(1'b1, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1);
    drain();

    // Back-to-back stream with random s_valid and m_ready gaps.
    fork
      begin
        foreach (tbl[i]) begin
          send(1'b0, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        repeat (250) begin
          @(posedge clk); #1;
          m_ready8 = ($urandom_range(0, 3) != 0);
        end
        m_ready8 = 1'b1;
      end
    join
    m_ready8 = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
